// File: rtl/multi_trip_math.sv
// Multi-channel trip timer: captures per-channel trip counts from a common start, then
// computes a saturated sum of squares X and its integer square root Y.
module multi_trip_math #(
    parameter int unsigned   NCH     = 2,
    parameter int unsigned   CW      = 16,
    parameter logic [CW-1:0] TIMEOUT = {CW{1'b1}}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              startSequence,
    input  logic              mode,
    input  logic [NCH-1:0]    tripped,
    output logic              complete,
    output logic              busy,
    output logic              timed_out,
    output logic [NCH-1:0]    trip_mask,
    output logic [2*CW-1:0]   X,
    output logic [CW-1:0]     Y
);
    localparam int unsigned   IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned   BW       = $clog2(CW + 1);
    localparam logic [IW-1:0] LAST_CH  = IW'(NCH - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CW - 1);

    typedef enum logic [2:0] {StIdle, StArm, StAccum, StSqrt, StDone} state_e;

    state_e          state;
    logic [CW-1:0]   counter;
    logic [CW-1:0]   cnt [NCH];
    logic            mode_q;
    logic [IW-1:0]   ch_idx;
    logic [2*CW-1:0] acc;
    logic [2*CW-1:0] rad;
    logic [CW:0]     rem;
    logic [CW-1:0]   root;
    logic [BW-1:0]   bit_idx;

    logic [NCH-1:0]  new_trip;
    logic [NCH-1:0]  mask_next;
    logic [CW-1:0]   sel;
    logic [CW-1:0]   term;
    logic [2*CW-1:0] sq;
    logic [2*CW:0]   sum;
    logic [2*CW-1:0] acc_next;
    logic [CW+2:0]   trial;
    logic [CW+2:0]   test;
    logic            fits;
    logic [CW:0]     rem_next;
    logic [CW-1:0]   root_next;

    always_comb begin
        new_trip  = tripped & ~trip_mask;
        mask_next = trip_mask | new_trip;

        sel = cnt[ch_idx];
        if (!mode_q) begin
            term = sel;
        end else if (sel >= cnt[0]) begin
            term = sel - cnt[0];
        end else begin
            term = cnt[0] - sel;
        end
        sq       = {{CW{1'b0}}, term} * {{CW{1'b0}}, term};
        sum      = {1'b0, acc} + {1'b0, sq};
        acc_next = sum[2*CW] ? {(2*CW){1'b1}} : sum[2*CW-1:0];

        // Restoring root step: bring down two radicand bits, try subtracting 4*root+1.
        trial     = {rem, rad[2*CW-1 -: 2]};
        test      = {1'b0, root, 2'b01};
        fits      = (trial >= test);
        rem_next  = fits ? (CW+1)'(trial - test) : (CW+1)'(trial);
        root_next = {root[CW-2:0], fits};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= StIdle;
            counter   <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            mode_q    <= 1'b0;
            ch_idx    <= '0;
            acc       <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            bit_idx   <= '0;
            complete  <= 1'b0;
            busy      <= 1'b0;
            timed_out <= 1'b0;
            trip_mask <= '0;
            X         <= '0;
            Y         <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (startSequence) begin
                        state     <= StArm;
                        mode_q    <= mode;
                        counter   <= '0;
                        for (int i = 0; i < NCH; i++) cnt[i] <= '0;
                        trip_mask <= '0;
                        timed_out <= 1'b0;
                        complete  <= 1'b0;
                        busy      <= 1'b1;
                        acc       <= '0;
                        ch_idx    <= '0;
                    end
                end
                StArm: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (new_trip[i]) cnt[i] <= counter;
                    end
                    trip_mask <= mask_next;
                    counter   <= counter + CW'(1);
                    // A trip landing on the timeout cycle closes the channel normally.
                    if (&mask_next) begin
                        state <= StAccum;
                    end else if (counter == TIMEOUT) begin
                        for (int i = 0; i < NCH; i++) begin
                            if (!mask_next[i]) cnt[i] <= TIMEOUT;
                        end
                        timed_out <= 1'b1;
                        state     <= StAccum;
                    end
                end
                StAccum: begin
                    acc    <= acc_next;
                    ch_idx <= ch_idx + IW'(1);
                    if (ch_idx == LAST_CH) begin
                        rad     <= acc_next;
                        rem     <= '0;
                        root    <= '0;
                        bit_idx <= '0;
                        state   <= StSqrt;
                    end
                end
                StSqrt: begin
                    rad     <= rad << 2;
                    rem     <= rem_next;
                    root    <= root_next;
                    bit_idx <= bit_idx + BW'(1);
                    if (bit_idx == LAST_BIT) begin
                        X        <= acc;
                        Y        <= root_next;
                        complete <= 1'b1;
                        busy     <= 1'b0;
                        state    <= StDone;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
